// File: rtl/control_sequencer_if.sv
// Bus between the control sequencer and the rest of the SAP-style datapath.
// The master side is the sequencer: it reads the IR opcode and ALU flags and
// drives the control word plus its status outputs.
interface control_sequencer_if #(
  parameter int OPCODE_W  = 4,
  parameter int MAX_STEPS = 6
);
  localparam int SW = $clog2(MAX_STEPS + 1);

  logic [OPCODE_W-1:0] opcode;
  logic                flag_z;
  logic                flag_c;
  logic [15:0]         ctrl;
  logic [SW-1:0]       stage;
  logic                instr_done;
  logic                halted;
  logic                illegal_op;

  modport master (
    input  opcode, flag_z, flag_c,
    output ctrl, stage, instr_done, halted, illegal_op
  );

  modport slave (
    output opcode, flag_z, flag_c,
    input  ctrl, stage, instr_done, halted, illegal_op
  );
endinterface

// File: rtl/control_sequencer.sv
// Micro-sequencer for the 8-bit SAP-style CPU.
// Steps through fetch (T0..T2) and a variable-length execute phase, returning
// to T0 right after each instruction's final micro-step. State moves on the
// falling clock edge so the control word is stable for the datapath's rising
// edge. HLT (and optionally an illegal opcode) parks the sequencer in HALT
// until resetn is asserted.
// Optional feature macro: SINGLE_STEP_EN adds a step_en input that freezes the
// sequencer and idles the control word while low.
module control_sequencer #(
  parameter int OPCODE_W        = 4,
  parameter int MAX_STEPS       = 6,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input logic clk,
  input logic resetn,
`ifdef SINGLE_STEP_EN
  input logic step_en,
`endif
  control_sequencer_if.master bus
);

  localparam int SW = $clog2(MAX_STEPS + 1);

  // Idle word: every active-low pin high, every active-high pin low.
  localparam logic [15:0] CTRL_IDLE = 16'h1FC7;

  localparam int B_PC_INC       = 15;
  localparam int B_PC_EN        = 14;
  localparam int B_PC_LOAD      = 13;
  localparam int B_MAR_ADDR_N   = 12;
  localparam int B_MAR_MEM_N    = 11;
  localparam int B_RAM_EN_N     = 10;
  localparam int B_RAM_LOAD_N   = 9;
  localparam int B_IR_LOAD_N    = 8;
  localparam int B_IR_EN_N      = 7;
  localparam int B_REGA_LOAD_N  = 6;
  localparam int B_REGA_EN      = 5;
  localparam int B_ADDER_SUB    = 4;
  localparam int B_ALU_EN       = 3;
  localparam int B_REGB_LOAD_N  = 2;
  localparam int B_OUT_LOAD_N   = 1;
  localparam int B_FLAGS_LOAD_N = 0;

  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_NOP = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(10);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_HALT
  } state_t;

  state_t        state;
  logic [SW-1:0] step;
  logic [SW-1:0] last_step;
  logic          legal;
  logic          is_halt_op;
  logic [15:0]   ctrl_word;
  logic          done;
  logic          illegal;

`ifndef SINGLE_STEP_EN
  logic step_en;
  assign step_en = 1'b1;
`endif

  // Decode the opcode into its final micro-step and whether it ends in HALT.
  always_comb begin
    legal      = 1'b1;
    is_halt_op = 1'b0;
    last_step  = SW'(3);
    case (bus.opcode)
      OP_ADD, OP_SUB, OP_STA: last_step = SW'(5);
      OP_LDA:                 last_step = SW'(4);
      OP_HLT:                 is_halt_op = 1'b1;
      OP_NOP, OP_OUT, OP_JMP, OP_JZ, OP_JC, OP_LDI: ;
      default: begin
        legal      = 1'b0;
        is_halt_op = HALT_ON_ILLEGAL;
      end
    endcase
  end

  // Build the control word and status strobes for the current micro-step.
  always_comb begin
    ctrl_word = CTRL_IDLE;
    done      = 1'b0;
    illegal   = 1'b0;
    if (state == S_RUN && step_en) begin
      case (step)
        SW'(0): begin
          ctrl_word[B_PC_EN]      = 1'b1;
          ctrl_word[B_MAR_ADDR_N] = 1'b0;
        end
        SW'(1): ctrl_word[B_PC_INC] = 1'b1;
        SW'(2): begin
          ctrl_word[B_RAM_EN_N]  = 1'b0;
          ctrl_word[B_IR_LOAD_N] = 1'b0;
        end
        default: begin
          done    = (step == last_step);
          illegal = (step == SW'(3)) && !legal;
          case (bus.opcode)
            OP_ADD, OP_SUB: begin
              if (step == SW'(3)) begin
                ctrl_word[B_IR_EN_N]    = 1'b0;
                ctrl_word[B_MAR_ADDR_N] = 1'b0;
              end else if (step == SW'(4)) begin
                ctrl_word[B_RAM_EN_N]    = 1'b0;
                ctrl_word[B_REGB_LOAD_N] = 1'b0;
              end else if (step == SW'(5)) begin
                ctrl_word[B_ALU_EN]       = 1'b1;
                ctrl_word[B_REGA_LOAD_N]  = 1'b0;
                ctrl_word[B_FLAGS_LOAD_N] = 1'b0;
                ctrl_word[B_ADDER_SUB]    = (bus.opcode == OP_SUB);
              end
            end
            OP_LDA: begin
              if (step == SW'(3)) begin
                ctrl_word[B_IR_EN_N]    = 1'b0;
                ctrl_word[B_MAR_ADDR_N] = 1'b0;
              end else if (step == SW'(4)) begin
                ctrl_word[B_RAM_EN_N]    = 1'b0;
                ctrl_word[B_REGA_LOAD_N] = 1'b0;
              end
            end
            OP_OUT: begin
              if (step == SW'(3)) begin
                ctrl_word[B_REGA_EN]    = 1'b1;
                ctrl_word[B_OUT_LOAD_N] = 1'b0;
              end
            end
            OP_STA: begin
              if (step == SW'(3)) begin
                ctrl_word[B_IR_EN_N]    = 1'b0;
                ctrl_word[B_MAR_ADDR_N] = 1'b0;
              end else if (step == SW'(4)) begin
                ctrl_word[B_REGA_EN]   = 1'b1;
                ctrl_word[B_MAR_MEM_N] = 1'b0;
              end else if (step == SW'(5)) begin
                ctrl_word[B_RAM_LOAD_N] = 1'b0;
              end
            end
            OP_JMP: begin
              if (step == SW'(3)) begin
                ctrl_word[B_IR_EN_N] = 1'b0;
                ctrl_word[B_PC_LOAD] = 1'b1;
              end
            end
            OP_JZ: begin
              if (step == SW'(3) && bus.flag_z) begin
                ctrl_word[B_IR_EN_N] = 1'b0;
                ctrl_word[B_PC_LOAD] = 1'b1;
              end
            end
            OP_JC: begin
              if (step == SW'(3) && bus.flag_c) begin
                ctrl_word[B_IR_EN_N] = 1'b0;
                ctrl_word[B_PC_LOAD] = 1'b1;
              end
            end
            OP_LDI: begin
              if (step == SW'(3)) begin
                ctrl_word[B_IR_EN_N]     = 1'b0;
                ctrl_word[B_REGA_LOAD_N] = 1'b0;
              end
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  // Falling-edge sequencer: HOLD -> T0, advance steps, wrap or halt after the last step.
  always_ff @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_HOLD;
      step  <= '0;
    end else if (step_en) begin
      case (state)
        S_HOLD: begin
          state <= S_RUN;
          step  <= '0;
        end
        S_RUN: begin
          if (step == last_step) begin
            step <= '0;
            if (is_halt_op) state <= S_HALT;
          end else begin
            step <= step + SW'(1);
          end
        end
        S_HALT: ;
        default: state <= S_HOLD;
      endcase
    end
  end

  assign bus.stage      = (state == S_RUN) ? step : '1;
  assign bus.halted     = (state == S_HALT);
  assign bus.ctrl       = ctrl_word;
  assign bus.instr_done = done;
  assign bus.illegal_op = illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer. The stimulus side describes each
// instruction as a list of asserted control signals and pushes the expected
// per-cycle outputs into a queue; a monitor pops and compares every cycle.
module tb_control_sequencer;

  localparam int          SW       = 3;
  localparam bit          HALT_ILL = 1'b0;
  localparam logic [15:0] IDLE     = 16'h1FC7;

  // Asserted-signal masks: XOR with IDLE yields the pin levels.
  localparam logic [15:0] A_PC_INC     = 16'h8000;
  localparam logic [15:0] A_PC_EN      = 16'h4000;
  localparam logic [15:0] A_PC_LOAD    = 16'h2000;
  localparam logic [15:0] A_MAR_ADDR   = 16'h1000;
  localparam logic [15:0] A_MAR_MEM    = 16'h0800;
  localparam logic [15:0] A_RAM_EN     = 16'h0400;
  localparam logic [15:0] A_RAM_LOAD   = 16'h0200;
  localparam logic [15:0] A_IR_LOAD    = 16'h0100;
  localparam logic [15:0] A_IR_EN      = 16'h0080;
  localparam logic [15:0] A_REGA_LOAD  = 16'h0040;
  localparam logic [15:0] A_REGA_EN    = 16'h0020;
  localparam logic [15:0] A_ADDER_SUB  = 16'h0010;
  localparam logic [15:0] A_ALU_EN     = 16'h0008;
  localparam logic [15:0] A_REGB_LOAD  = 16'h0004;
  localparam logic [15:0] A_OUT_LOAD   = 16'h0002;
  localparam logic [15:0] A_FLAGS_LOAD = 16'h0001;

  typedef struct packed {
    logic [SW-1:0] stage;
    logic [15:0]   ctrl;
    logic          done;
    logic          ill;
    logic          halted;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
`ifdef SINGLE_STEP_EN
  logic step_en;
`endif

  int checks = 0;
  int errors = 0;
  exp_t        sb[$];
  logic [15:0] prog[$];
  event        sample_ev;

  control_sequencer_if #(.OPCODE_W(4), .MAX_STEPS(6)) bus ();

  control_sequencer #(
    .OPCODE_W(4),
    .MAX_STEPS(6),
    .HALT_ON_ILLEGAL(HALT_ILL)
  ) dut (
    .clk(clk),
    .resetn(resetn),
`ifdef SINGLE_STEP_EN
    .step_en(step_en),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  // List the asserted signals for each micro-step of one instruction.
  task automatic fill_prog(input logic [3:0] op, input logic z, input logic c);
    prog.delete();
    prog.push_back(A_PC_EN | A_MAR_ADDR);
    prog.push_back(A_PC_INC);
    prog.push_back(A_RAM_EN | A_IR_LOAD);
    case (op)
      4'd2, 4'd3: begin
        prog.push_back(A_IR_EN | A_MAR_ADDR);
        prog.push_back(A_RAM_EN | A_REGB_LOAD);
        prog.push_back(A_ALU_EN | A_REGA_LOAD | A_FLAGS_LOAD | ((op == 4'd3) ? A_ADDER_SUB : 16'h0));
      end
      4'd4: begin
        prog.push_back(A_IR_EN | A_MAR_ADDR);
        prog.push_back(A_RAM_EN | A_REGA_LOAD);
      end
      4'd5: prog.push_back(A_REGA_EN | A_OUT_LOAD);
      4'd6: begin
        prog.push_back(A_IR_EN | A_MAR_ADDR);
        prog.push_back(A_REGA_EN | A_MAR_MEM);
        prog.push_back(A_RAM_LOAD);
      end
      4'd7:  prog.push_back(A_IR_EN | A_PC_LOAD);
      4'd8:  prog.push_back(z ? (A_IR_EN | A_PC_LOAD) : 16'h0);
      4'd9:  prog.push_back(c ? (A_IR_EN | A_PC_LOAD) : 16'h0);
      4'd10: prog.push_back(A_IR_EN | A_REGA_LOAD);
      default: prog.push_back(16'h0);
    endcase
  endtask

  function automatic void push_exp(input logic [SW-1:0] st, input logic [15:0] cw,
                                   input logic dn, input logic il, input logic hl);
    exp_t e;
    e.stage  = st;
    e.ctrl   = cw;
    e.done   = dn;
    e.ill    = il;
    e.halted = hl;
    sb.push_back(e);
  endfunction

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  task automatic check_output();
    exp_t e;
    exp_t got;
    e   = sb.pop_front();
    got = {bus.stage, bus.ctrl, bus.instr_done, bus.illegal_op, bus.halted};
    checks++;
    if (got !== e) begin
      errors++;
      $display("[TB] FAIL step @%0t got stage=%0d ctrl=%h done=%b ill=%b halted=%b want stage=%0d ctrl=%h done=%b ill=%b halted=%b",
               $time, got.stage, got.ctrl, got.done, got.ill, got.halted,
               e.stage, e.ctrl, e.done, e.ill, e.halted);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or sample_ev);
      if (sb.size() > 0) check_output();
    end
  end

  // Assert reset mid-cycle, check HOLD right away, release and land on T0.
  task automatic do_reset();
    resetn = 1'b0;
`ifdef SINGLE_STEP_EN
    step_en = 1'b1;
`endif
    #1;
    push_exp('1, IDLE, 1'b0, 1'b0, 1'b0);
    ->sample_ev;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    resetn = 1'b1;
    @(negedge clk);
    #1;
  endtask

  // Run one instruction from T0; abort_at >= 0 resets during that step.
  task automatic apply_stimulus(input logic [3:0] op, input logic z, input logic c, input int abort_at);
    int  n;
    bit  halts;
    bit  ill;
    fill_prog(op, z, c);
    n     = prog.size();
    ill   = (op > 4'd10);
    halts = (op == 4'd0) || (ill && HALT_ILL);
    bus.opcode = op;
    bus.flag_z = z;
    bus.flag_c = c;
    for (int k = 0; k < n; k++) begin
`ifdef SINGLE_STEP_EN
      begin
        int stalls;
        stalls = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
        for (int s = 0; s < stalls; s++) begin
          step_en = 1'b0;
          push_exp(SW'(k), IDLE, 1'b0, 1'b0, 1'b0);
          @(negedge clk);
          #1;
        end
        step_en = 1'b1;
      end
`endif
      push_exp(SW'(k), IDLE ^ prog[k], (k == n - 1), (ill && k == 3), 1'b0);
      if (k == abort_at) begin
        @(posedge clk);
        #2;
        do_reset();
        return;
      end
      @(negedge clk);
      #1;
    end
    if (halts) begin
      for (int h = 0; h < 25; h++) begin
        push_exp('1, IDLE, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
      end
      @(posedge clk);
      #2;
      do_reset();
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired with %0d expectations pending", sb.size());
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] op;
    int         abort_at;
    resetn     = 1'b0;
    bus.opcode = '0;
    bus.flag_z = 1'b0;
    bus.flag_c = 1'b0;
`ifdef SINGLE_STEP_EN
    step_en = 1'b1;
`endif
    #3;
    push_exp('1, IDLE, 1'b0, 1'b0, 1'b0);
    ->sample_ev;
    @(posedge clk);
    #2;
    resetn = 1'b1;
    @(negedge clk);
    #1;

    // Small program ending in HLT, then reset out of HALT.
    apply_stimulus(4'd4, 1'b0, 1'b0, -1);
    apply_stimulus(4'd2, 1'b1, 1'b0, -1);
    apply_stimulus(4'd5, 1'b0, 1'b1, -1);
    apply_stimulus(4'd0, 1'b0, 1'b0, -1);
    // Reset in the middle of STA at T4.
    apply_stimulus(4'd6, 1'b0, 1'b0, 4);
    // Conditional jumps, SUB, illegal opcode.
    apply_stimulus(4'd8, 1'b0, 1'b1, -1);
    apply_stimulus(4'd8, 1'b1, 1'b0, -1);
    apply_stimulus(4'd9, 1'b1, 1'b0, -1);
    apply_stimulus(4'd9, 1'b0, 1'b1, -1);
    apply_stimulus(4'd3, 1'b0, 1'b0, -1);
    apply_stimulus(4'hF, 1'b0, 1'b0, -1);

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd0 && $urandom_range(0, 3) != 0) op = 4'd1;
      abort_at = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : -1;
      apply_stimulus(op, 1'($urandom), 1'($urandom), abort_at);
    end

    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending=%0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
